alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 2, skid-buffer entry count; only 2 supported.
REQ-002 SHALL have ports:
  clk  input  1  clock, all state on rising edge
  reset  input  1  asynchronous, active-low reset
  in_valid  input  1  ALU result valid; ALU en of the same op
  in_ready  output  1  stage can accept
  res  input  32  ALU result (Word)
  lt/gt/eq  input  1 each  ALU result flags
  ov/cout  input  1 each  ALU overflow/carry
  dest  input  5  target GPR
  crf  input  3  target CR field
  rc  input  1  record CR field
  oe  input  1  update XER OV/SO
  ca_en  input  1  update XER CA
  wb_valid  output  1  GPR write pending
  wb_ready  input  1  register file accepts write
  wb_addr  output  5  GPR address
  wb_data  output  32  GPR data
  cr_we  output  1  CR field write, qualified by wb_valid&&wb_ready
  cr_field  output  3  CR field index
  cr_data  output  4  {lt,gt,eq,so}
  xer_we  input  1  software XER write (mtxer)
  xer_wdata  input  3  {so,ov,ca}
  xer_so/xer_ov/xer_ca  output  1 each  architectural XER bits

Function
REQ-003 SHALL accept an entry when in_valid && in_ready at a rising edge.
REQ-004 SHALL drive in_ready = (count != 2), combinational on registered count only.
REQ-005 SHALL hold entries in a 2-entry FIFO; states EMPTY(0), ONE(1), FULL(2).
REQ-006 SHALL transition: push only +1; pop only -1; push+pop holds count; FULL never pushes.
REQ-007 SHALL pop when wb_valid && wb_ready; wb_valid = (count != 0).
REQ-008 SHALL present an entry accepted at edge N on wb_* from edge N onward (one-cycle latency), in acceptance order.
REQ-009 SHALL hold wb_addr/wb_data/cr_* stable while wb_valid && !wb_ready.
REQ-010 SHALL update XER at acceptance: ov_n = oe ? ov : xer_ov; so_n = xer_so | (oe & ov); ca_n = ca_en ? cout : xer_ca.
REQ-011 SHALL store cr_data = {lt,gt,eq,so_n} per entry, so_n including the same op's overflow.
REQ-012 SHALL drive cr_we = rc of head entry, 0 when EMPTY.
REQ-013 SHALL keep SO sticky: cleared only by xer_we or reset.
REQ-014 SHALL, on xer_we, load {xer_so,xer_ov,xer_ca} = xer_wdata at the edge.
REQ-015 SHALL give xer_we priority over a simultaneous accepted op's XER update; the op's CR so still uses its REQ-010 so_n.
REQ-016 SHALL ignore res/flags/dest/crf/rc/oe/ca_en when in_valid is 0.
REQ-017 SHALL drive wb_data = 0, wb_addr = 0, cr_data = 0 when EMPTY.

Reset
REQ-018 SHALL, on reset low, asynchronously clear count to EMPTY, all XER bits to 0, wb_valid/cr_we to 0, in_ready to 1.
REQ-019 SHALL discard all buffered entries on reset mid-operation; no write issues after release.
REQ-020 SHALL accept input on the first rising edge after reset deassertion.

Structure
REQ-021 SHALL take Word from Pu_types; SHALL add Wb_entry struct (data, addr, crf, cr_data, rc) and Xer struct {so,ov,ca} to Pu_types.
REQ-022 SHALL implement storage as one sub-module wb_skid_fifo (2 entries, push/pop/count) instantiated once.

Verification
REQ-023 Add op res=0x8000_0000, lt=1, ov=1, oe=1, rc=1, crf=3, wb_ready=1 -> next cycle wb_data=0x8000_0000, cr_field=3, cr_data=4'b1001, xer_so=1, xer_ov=1.
REQ-024 Then op ov=0, oe=1, rc=1, eq=1 -> xer_ov=0, xer_so=1, cr_data=4'b0011; xer_we=3'b000 -> xer_so=0.
REQ-025 wb_ready=0, push dest=1,2 -> FULL, in_ready=0, third op held; wb_ready=1 -> writes addr 1,2,3 in order, each data stable while stalled.
REQ-026 FULL with simultaneous in_valid and pop -> pop only, count 1, in_ready=1 next cycle; ONE with push+pop -> count stays 1.
REQ-027 ca_en=1, cout=1 then ca_en=0, cout=0 -> xer_ca stays 1; xer_we=3'b001 with accepted op oe=1, ov=1 same edge -> xer_so=0, xer_ca=1, that op's cr_data[0]=1.
REQ-028 Reset low while FULL and mid-stall -> wb_valid=0, XER=0 immediately; release with wb_ready=1 -> no write until new op accepted.

Source files
------------

// File: rtl/pu_types.sv
// Shared processing-unit types: machine word, XER bits, writeback entry and
// skid-buffer occupancy states.
package pu_types;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic so;
        logic ov;
        logic ca;
    } xer_t;

    typedef struct packed {
        word_t      data;
        logic [4:0] addr;
        logic [2:0] crf;
        logic [3:0] cr_data;
        logic       rc;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_count_e;

    // XER image after one ALU op; SO accumulates this op's overflow when oe is set.
    function automatic xer_t xer_after_op(xer_t cur, logic oe, logic ov,
                                          logic ca_en, logic cout);
        xer_t nxt;
        nxt.so = cur.so | (oe & ov);
        nxt.ov = oe ? ov : cur.ov;
        nxt.ca = ca_en ? cout : cur.ca;
        return nxt;
    endfunction

endpackage

// File: rtl/wb_skid_fifo.sv
// Two-entry writeback skid buffer: in-order storage with push/pop and an
// occupancy state machine (EMPTY/ONE/FULL).
module wb_skid_fifo
    import pu_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  wb_entry_t   entry_i,
    input  logic        pop_i,
    output wb_entry_t   head_o,
    output fifo_count_e count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fifo_count_e      count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    wb_entry_t        mem_q [DEPTH];
    logic             push_ok, pop_ok;

    // A full buffer never takes a push, even when it pops on the same edge.
    assign push_ok = push_i && (count_q != FULL);
    assign pop_ok  = pop_i && (count_q != EMPTY);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // NOTE: storage is not reset; occupancy gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= entry_i;
    end

    // NOTE: combinational blocks assign a default first so no path infers a latch.
    always_comb begin
        count_d = count_q;
        case (count_q)
            EMPTY:   if (push_ok) count_d = ONE;
            ONE: begin
                if (push_ok && !pop_ok)      count_d = FULL;
                else if (pop_ok && !push_ok) count_d = EMPTY;
            end
            FULL:    if (pop_ok) count_d = ONE;
            default: count_d = EMPTY;
        endcase
    end

    always_comb begin
        count_o = count_q;
        head_o  = mem_q[rd_ptr_q];
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: buffers results for the GPR/CR write port and keeps
// the architectural XER (SO/OV/CA) up to date at op acceptance.
module alu_writeback
    import pu_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  word_t       res,
    input  logic        lt,
    input  logic        gt,
    input  logic        eq,
    input  logic        ov,
    input  logic        cout,
    input  logic [4:0]  dest,
    input  logic [2:0]  crf,
    input  logic        rc,
    input  logic        oe,
    input  logic        ca_en,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_addr,
    output word_t       wb_data,
    output logic        cr_we,
    output logic [2:0]  cr_field,
    output logic [3:0]  cr_data,
    input  logic        xer_we,
    input  logic [2:0]  xer_wdata,
    output logic        xer_so,
    output logic        xer_ov,
    output logic        xer_ca
);

    xer_t        xer_q, xer_d, op_xer;
    wb_entry_t   new_entry, head;
    fifo_count_e count;
    logic        accept, pop;

    assign in_ready = (count != FULL);
    assign wb_valid = (count != EMPTY);
    assign accept   = in_valid && in_ready;
    assign pop      = wb_valid && wb_ready;

    // The op's CR copy of SO always reflects its own overflow, even when an
    // mtxer on the same edge overrides the architectural XER.
    always_comb begin
        op_xer            = xer_after_op(xer_q, oe, ov, ca_en, cout);
        new_entry.data    = res;
        new_entry.addr    = dest;
        new_entry.crf     = crf;
        new_entry.cr_data = {lt, gt, eq, op_xer.so};
        new_entry.rc      = rc;
    end

    always_comb begin
        xer_d = xer_q;
        if (xer_we)      xer_d = xer_t'(xer_wdata);
        else if (accept) xer_d = op_xer;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) xer_q <= '0;
        else        xer_q <= xer_d;
    end

    wb_skid_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .entry_i (new_entry),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    always_comb begin
        wb_addr  = '0;
        wb_data  = '0;
        cr_field = '0;
        cr_data  = '0;
        cr_we    = 1'b0;
        if (wb_valid) begin
            wb_addr  = head.addr;
            wb_data  = head.data;
            cr_field = head.crf;
            cr_data  = head.cr_data;
            cr_we    = head.rc;
        end
    end

    assign xer_so = xer_q.so;
    assign xer_ov = xer_q.ov;
    assign xer_ca = xer_q.ca;

endmodule

// File: tb/tb_alu_writeback.sv
// Self-checking bench for alu_writeback: directed vector table, hand-written
// stall/reset sequences and a randomized run against a queue-based model.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [31:0] res;
    logic        lt, gt, eq, ov, cout;
    logic [4:0]  dest;
    logic [2:0]  crf;
    logic        rc, oe, ca_en;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        cr_we;
    logic [2:0]  cr_field;
    logic [3:0]  cr_data;
    logic        xer_we;
    logic [2:0]  xer_wdata;
    logic        xer_so, xer_ov, xer_ca;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_writeback #(.DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .res       (res),
        .lt        (lt),
        .gt        (gt),
        .eq        (eq),
        .ov        (ov),
        .cout      (cout),
        .dest      (dest),
        .crf       (crf),
        .rc        (rc),
        .oe        (oe),
        .ca_en     (ca_en),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .cr_we     (cr_we),
        .cr_field  (cr_field),
        .cr_data   (cr_data),
        .xer_we    (xer_we),
        .xer_wdata (xer_wdata),
        .xer_so    (xer_so),
        .xer_ov    (xer_ov),
        .xer_ca    (xer_ca)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: FIFO of pending writes + XER bits
    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        logic [2:0]  crf;
        logic [3:0]  cr;
        logic        rc;
    } exp_t;

    exp_t     mq[$];
    logic [2:0] m_xer;   // {so, ov, ca}

    task automatic check_outputs(input string tag);
        check({tag, " wb_valid"}, 32'(wb_valid), 32'(mq.size() > 0));
        check({tag, " in_ready"}, 32'(in_ready), 32'(mq.size() < 2));
        check({tag, " xer"}, 32'({xer_so, xer_ov, xer_ca}), 32'(m_xer));
        if (mq.size() > 0) begin
            check({tag, " wb_data"},  wb_data,          mq[0].data);
            check({tag, " wb_addr"},  32'(wb_addr),     32'(mq[0].addr));
            check({tag, " cr_field"}, 32'(cr_field),    32'(mq[0].crf));
            check({tag, " cr_data"},  32'(cr_data),     32'(mq[0].cr));
            check({tag, " cr_we"},    32'(cr_we),       32'(mq[0].rc));
        end else begin
            check({tag, " wb_data"},  wb_data,       32'd0);
            check({tag, " wb_addr"},  32'(wb_addr),  32'd0);
            check({tag, " cr_data"},  32'(cr_data),  32'd0);
            check({tag, " cr_we"},    32'(cr_we),    32'd0);
        end
    endtask

    // One clock edge: model sees pre-edge inputs, outputs compared #1 after.
    task automatic step(input string tag);
        bit   acc, pop;
        logic so_n, ov_n, ca_n;
        exp_t e;
        acc  = in_valid && (mq.size() < 2);
        pop  = (mq.size() > 0) && wb_ready;
        so_n = m_xer[2] | (oe & ov);
        ov_n = oe ? ov : m_xer[1];
        ca_n = ca_en ? cout : m_xer[0];
        e = '{data: res, addr: dest, crf: crf, cr: {lt, gt, eq, so_n}, rc: rc};
        @(posedge clk);
        #1;
        if (pop) void'(mq.pop_front());
        if (acc) mq.push_back(e);
        if (xer_we)   m_xer = xer_wdata;
        else if (acc) m_xer = {so_n, ov_n, ca_n};
        check_outputs(tag);
    endtask

    task automatic idle_inputs();
        in_valid = 0; res = '0; lt = 0; gt = 0; eq = 0; ov = 0; cout = 0;
        dest = '0; crf = '0; rc = 0; oe = 0; ca_en = 0;
        wb_ready = 1; xer_we = 0; xer_wdata = '0;
    endtask

    task automatic set_op(input logic [31:0] r, input logic [4:0] d, input logic o_e, input logic o_v);
        in_valid = 1; res = r; dest = d; crf = d[2:0]; rc = d[0];
        lt = 0; gt = 1; eq = 0; oe = o_e; ov = o_v; ca_en = 0; cout = 0;
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic        iv;
        logic [31:0] r;
        logic        l, g, e, o, c;
        logic [4:0]  d;
        logic [2:0]  f;
        logic        rc_, oe_, ca_, rdy, xwe;
        logic [2:0]  xwd;
        logic        e_valid;
        logic [31:0] e_data;
        logic [4:0]  e_addr;
        logic [2:0]  e_crf;
        logic [3:0]  e_cr;
        logic        e_we;
        logic [2:0]  e_xer;
        logic        e_ready;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // iv  res           l  g  e  ov c  dest crf   rc oe ca rdy xwe xwd   | valid data          addr crf  cr       we xer     rdy
        vecs[0] = '{1, 32'h8000_0000, 1, 0, 0, 1, 0, 5'd5, 3'd3, 1, 1, 0, 1, 0, 3'b000, 1, 32'h8000_0000, 5'd5, 3'd3, 4'b1001, 1, 3'b110, 1};
        vecs[1] = '{1, 32'h0000_1234, 0, 0, 1, 0, 0, 5'd6, 3'd2, 1, 1, 0, 1, 0, 3'b000, 1, 32'h0000_1234, 5'd6, 3'd2, 4'b0011, 1, 3'b100, 1};
        vecs[2] = '{0, 32'hdead_beef, 1, 1, 1, 1, 1, 5'd9, 3'd7, 1, 1, 1, 1, 1, 3'b000, 0, 32'h0,          5'd0, 3'd0, 4'b0000, 0, 3'b000, 1};
        vecs[3] = '{1, 32'h0000_0007, 0, 0, 0, 0, 1, 5'd7, 3'd1, 0, 0, 1, 1, 0, 3'b000, 1, 32'h0000_0007, 5'd7, 3'd1, 4'b0000, 0, 3'b001, 1};
        vecs[4] = '{1, 32'h0000_0008, 0, 1, 0, 0, 0, 5'd8, 3'd0, 1, 0, 0, 1, 0, 3'b000, 1, 32'h0000_0008, 5'd8, 3'd0, 4'b0100, 1, 3'b001, 1};
        vecs[5] = '{1, 32'h0000_0009, 0, 0, 0, 1, 0, 5'd9, 3'd4, 1, 1, 0, 1, 1, 3'b001, 1, 32'h0000_0009, 5'd9, 3'd4, 4'b0001, 1, 3'b001, 1};
        vecs[6] = '{0, 32'h0,         0, 0, 0, 0, 0, 5'd0, 3'd0, 0, 0, 0, 1, 0, 3'b000, 0, 32'h0,          5'd0, 3'd0, 4'b0000, 0, 3'b001, 1};

        idle_inputs();
        reset = 0;
        mq.delete();
        m_xer = 3'b000;

        // Asynchronous reset state, before any clock edge.
        #3;
        check("rst wb_valid", 32'(wb_valid), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);
        check("rst cr_we",    32'(cr_we),    32'd0);
        check("rst xer",      32'({xer_so, xer_ov, xer_ca}), 32'd0);
        check("rst wb_data",  wb_data,       32'd0);

        @(negedge clk);
        reset = 1;

        // Table: first row is taken on the first edge after release.
        for (int i = 0; i < 7; i++) begin
            in_valid = vecs[i].iv;  res = vecs[i].r;
            lt = vecs[i].l; gt = vecs[i].g; eq = vecs[i].e; ov = vecs[i].o; cout = vecs[i].c;
            dest = vecs[i].d; crf = vecs[i].f; rc = vecs[i].rc_; oe = vecs[i].oe_; ca_en = vecs[i].ca_;
            wb_ready = vecs[i].rdy; xer_we = vecs[i].xwe; xer_wdata = vecs[i].xwd;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_valid));
            check($sformatf("vec%0d wb_data", i),  wb_data,       vecs[i].e_data);
            check($sformatf("vec%0d wb_addr", i),  32'(wb_addr),  32'(vecs[i].e_addr));
            check($sformatf("vec%0d cr_field", i), 32'(cr_field), 32'(vecs[i].e_crf));
            check($sformatf("vec%0d cr_data", i),  32'(cr_data),  32'(vecs[i].e_cr));
            check($sformatf("vec%0d cr_we", i),    32'(cr_we),    32'(vecs[i].e_we));
            check($sformatf("vec%0d xer", i),      32'({xer_so, xer_ov, xer_ca}), 32'(vecs[i].e_xer));
            check($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].e_ready));
        end
        mq.delete();
        m_xer = 3'b001;
        idle_inputs();

        // Stall: fill to FULL, hold a third op, then drain in order.
        wb_ready = 0;
        set_op(32'h11, 5'd1, 0, 0); step("stall push1");
        set_op(32'h22, 5'd2, 0, 0); step("stall push2");
        check("full in_ready", 32'(in_ready), 32'd0);
        set_op(32'h33, 5'd3, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("stall hold");
            check("stall addr stable", 32'(wb_addr), 32'd1);
            check("stall data stable", wb_data, 32'h11);
        end
        wb_ready = 1;
        step("full pop only");
        check("full pop addr", 32'(wb_addr), 32'd2);
        check("after full pop in_ready", 32'(in_ready), 32'd1);
        step("one push+pop");
        check("one push+pop addr", 32'(wb_addr), 32'd3);
        check("one push+pop count", 32'(in_ready && wb_valid), 32'd1);
        in_valid = 0;
        step("drain");
        check("drained", 32'(wb_valid), 32'd0);

        // Reset while FULL and stalled, with sticky SO set.
        wb_ready = 0;
        set_op(32'haa, 5'd10, 1, 1); step("pre-rst push1");
        set_op(32'hbb, 5'd11, 0, 0); step("pre-rst push2");
        #2;
        reset = 0;
        #1;
        check("mid rst wb_valid", 32'(wb_valid), 32'd0);
        check("mid rst in_ready", 32'(in_ready), 32'd1);
        check("mid rst cr_we",    32'(cr_we),    32'd0);
        check("mid rst xer",      32'({xer_so, xer_ov, xer_ca}), 32'd0);
        mq.delete();
        m_xer = 3'b000;
        idle_inputs();
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 3; i++) step("post rst idle");
        set_op(32'hcc, 5'd12, 0, 0); step("post rst accept");
        check("post rst addr", 32'(wb_addr), 32'd12);
        idle_inputs();
        step("post rst drain");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 99) < 65);
            res       = $urandom();
            lt        = 1'($urandom()); gt = 1'($urandom()); eq = 1'($urandom());
            ov        = 1'($urandom()); cout = 1'($urandom());
            dest      = 5'($urandom()); crf = 3'($urandom());
            rc        = 1'($urandom()); oe = 1'($urandom()); ca_en = 1'($urandom());
            wb_ready  = ($urandom_range(0, 99) < 60);
            xer_we    = ($urandom_range(0, 99) < 6);
            xer_wdata = 3'($urandom());
            step("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
